// File: rtl/bidir_shift_receiver.sv
// bidir_shift_receiver: serial-to-parallel frame receiver with direction-aware bit placement and a one-entry valid/ready buffer
module bidir_shift_receiver #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         SI,
    input  logic         start,
    input  logic         R_L_n,
    input  logic         ready,
    input  logic         clr_ovr,
    output logic [n-1:0] data_out,
    output logic         valid,
    output logic         busy,
    output logic         overrun
);
    localparam int CW = $clog2(n) + 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [n-1:0]  sr, sr_nxt;
    logic [CW-1:0] cnt;
    logic          dir, shift_dir, sample, complete, consume;

    // Next state, shifted word and buffer handshake terms
    always_comb begin
        shift_dir = (state == IDLE) ? R_L_n : dir;
        sample    = (state == SHIFT) | start;
        complete  = (state == SHIFT) && (cnt == LAST);
        consume   = valid & ready;
        sr_nxt    = shift_dir ? {SI, sr[n-1:1]} : {sr[n-2:0], SI};
        state_nxt = (state == IDLE) ? (start ? SHIFT : IDLE) : (complete ? IDLE : SHIFT);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shift register, bit counter and direction latched at frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= '0;
            cnt <= '0;
            dir <= 1'b1;
        end else if (sample) begin
            sr  <= sr_nxt;
            cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
            if (state == IDLE) dir <= R_L_n;
        end
    end

    // Output buffer: a completed word replaces a consumed or empty slot, otherwise it is dropped and flagged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (complete && (!valid || ready)) begin
                data_out <= sr_nxt;
                valid    <= 1'b1;
            end else if (consume) begin
                valid    <= 1'b0;
            end
            if (complete && valid && !ready) overrun <= 1'b1;
            else if (clr_ovr)                overrun <= 1'b0;
        end
    end

    assign busy = (state == SHIFT);
endmodule

// File: tb/tb_bidir_shift_receiver.sv
// tb_bidir_shift_receiver: directed checks of frame assembly, buffering, overrun and reset behaviour
module tb_bidir_shift_receiver;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       SI = 1'b0;
    logic       start = 1'b0;
    logic       R_L_n = 1'b0;
    logic       ready = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [3:0] data_out;
    logic       valid, busy, overrun;
    logic       v_first, d_first;
    logic [3:0] w_first;
    int         tests = 0;
    int         errors = 0;

    bidir_shift_receiver #(.n(4)) dut (
        .clk(clk), .reset_n(reset_n), .SI(SI), .start(start), .R_L_n(R_L_n),
        .ready(ready), .clr_ovr(clr_ovr), .data_out(data_out), .valid(valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // seq[i] is the i-th bit on SI; rdy[i] is ready during that bit; tog flips R_L_n after the start bit
    task automatic frame(input logic [3:0] seq, input logic d, input logic tog, input logic [3:0] rdy);
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            SI    = seq[i];
            R_L_n = (i != 0 && tog) ? ~d : d;
            ready = rdy[i];
            @(posedge clk);
            #1;
            if (i == 0) begin
                chk("busy_mid", busy, 1);
                v_first = valid;
                w_first = data_out;
            end
        end
        start = 1'b0;
        SI    = 1'b0;
        ready = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        #2 reset_n = 1'b1;
        tick();

        frame(4'b1101, 1'b1, 1'b0, 4'b0000);
        chk("right_data", data_out, 4'b1101);
        chk("right_valid", valid, 1);
        chk("right_busy", busy, 0);
        chk("right_ovr", overrun, 0);

        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("consume_valid", valid, 0);
        chk("consume_hold", data_out, 4'b1101);

        frame(4'b1010, 1'b0, 1'b0, 4'b0000);
        chk("left_data", data_out, 4'b0101);
        chk("left_valid", valid, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        frame(4'b1010, 1'b0, 1'b1, 4'b0000);
        chk("left_tog_data", data_out, 4'b0101);
        chk("left_tog_valid", valid, 1);

        frame(4'b1111, 1'b1, 1'b0, 4'b1111);
        chk("b2b1_data", data_out, 4'b1111);
        chk("b2b1_valid", valid, 1);
        frame(4'b1000, 1'b1, 1'b0, 4'b1111);
        chk("b2b_gap_valid", v_first, 0);
        chk("b2b_gap_hold", w_first, 4'b1111);
        chk("b2b2_data", data_out, 4'b1000);
        chk("b2b2_valid", valid, 1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("b2b2_drop", valid, 0);

        frame(4'b1101, 1'b1, 1'b0, 4'b0000);
        chk("ovr_first", data_out, 4'b1101);
        frame(4'b0110, 1'b1, 1'b0, 4'b0000);
        chk("ovr_data", data_out, 4'b1101);
        chk("ovr_flag", overrun, 1);
        chk("ovr_valid", valid, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("clr_flag", overrun, 0);
        chk("clr_valid", valid, 1);
        clr_ovr = 1'b1;
        frame(4'b0001, 1'b1, 1'b0, 4'b0000);
        clr_ovr = 1'b0;
        chk("set_wins", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("clr2_flag", overrun, 0);

        frame(4'b0011, 1'b1, 1'b0, 4'b1000);
        chk("sim_data", data_out, 4'b0011);
        chk("sim_valid", valid, 1);
        chk("sim_ovr", overrun, 0);

        frame(4'b1111, 1'b1, 1'b0, 4'b0000);
        chk("pre_rst_ovr", overrun, 1);
        start = 1'b1;
        SI = 1'b1;
        R_L_n = 1'b1;
        tick();
        start = 1'b0;
        SI = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovr", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        frame(4'b1100, 1'b0, 1'b0, 4'b0000);
        chk("post_rst_data", data_out, 4'b0011);
        chk("post_rst_valid", valid, 1);
        chk("post_rst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
